// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//  - cfg field positions: {stop_sel, parity_en, parity_even, data_len[1:0]}
//  - receive FSM state encoding
//  - FIFO entry layout {brk, ferr, perr, data[7:0]}
//  - 3-sample majority helper used for bit decisions
package uart_pkg;

  localparam int CFG_W       = 5;
  localparam int CFG_STOP    = 4;
  localparam int CFG_PEN     = 3;
  localparam int CFG_PEVEN   = 2;
  localparam int CFG_LEN_MSB = 1;
  localparam int CFG_LEN_LSB = 0;

  localparam int ENTRY_W     = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_PUSH
  } rx_state_e;

  typedef struct packed {
    logic       brk;
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO holding received UART entries.
// Ports:
//  clk, rst_n   clock, synchronous active-low reset (pointers only)
//  wr_en        push request; accepted when not full or when a pop happens in the same cycle
//  wr_data      entry to push
//  rd_en        pop request; ignored while empty
//  rd_data      head entry (valid while !empty)
//  empty, full  occupancy flags
//  level        number of stored entries, 0..DEPTH
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_fire, rd_fire;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rd_fire  = rd_en && !empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    wr_fire  = wr_en && (!full || rd_fire);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
    level    = wr_ptr_q - rd_ptr_q;
    rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with output FIFO.
// Ports:
//  clk, rst_n   clock, synchronous active-low reset
//  tick16       1-cycle enable at 16x baud; all bit timing counts these
//  cfg          {stop_sel, parity_en, parity_even, data_len[1:0]}, captured at start edge
//  rx_sn        asynchronous serial input, idle high
//  rd_data      head entry data, right-aligned, upper bits 0 (0 while empty)
//  rd_perr/rd_ferr/rd_brk  head entry flags (0 while empty)
//  rd_valid     FIFO not empty; rd_ready pops the head
//  level        FIFO occupancy
//  overrun      sticky, set when a frame finishes while the FIFO is full; clr_err clears
//  busy         receive FSM not idle
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick16,
  input  logic [CFG_W-1:0]       cfg,
  input  logic                   rx_sn,
  output logic [7:0]             rd_data,
  output logic                   rd_perr,
  output logic                   rd_ferr,
  output logic                   rd_brk,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overrun,
  input  logic                   clr_err,
  output logic                   busy
);

  // ---- stage: input synchroniser
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxs;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx_sn};
    rxs    = sync_q[SYNC_STAGES-1];
  end

  // ---- stage: bit timing and receive FSM
  rx_state_e        state_q, state_d;
  logic [3:0]       tcnt_q, tcnt_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       data_q, data_d;
  logic             s7_q, s7_d, s8_q, s8_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic             perr_q, perr_d, ferr_q, ferr_d;
  logic             allz_q, allz_d;
  logic             brk_wait_q, brk_wait_d;
  logic             overrun_q, overrun_d;

  logic             mid, bit_end, bit_val, in_frame;
  logic [2:0]       last_bit;
  logic             push_req, ovr_set, can_push;
  logic             rd_pop, fifo_empty, fifo_full;
  logic [ENTRY_W-1:0] fifo_rd;
  rx_entry_t        push_entry, head;

  always_comb begin
    mid      = tick16 && (tcnt_q == 4'd9);
    bit_end  = tick16 && (tcnt_q == 4'd15);
    bit_val  = maj3(s7_q, s8_q, rxs);
    in_frame = (state_q != ST_IDLE) && (state_q != ST_PUSH);
    last_bit = 3'd4 + {1'b0, cfg_q[CFG_LEN_MSB:CFG_LEN_LSB]};
  end

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    bitcnt_d   = bitcnt_q;
    data_d     = data_q;
    s7_d       = s7_q;
    s8_d       = s8_q;
    cfg_d      = cfg_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    allz_d     = allz_q;
    brk_wait_d = brk_wait_q;
    push_req   = 1'b0;
    ovr_set    = 1'b0;

    if (in_frame && tick16) begin
      tcnt_d = tcnt_q + 4'd1;
      if (tcnt_q == 4'd7) s7_d = rxs;
      if (tcnt_q == 4'd8) s8_d = rxs;
    end

    case (state_q)
      ST_IDLE: begin
        // After a break the line must return high before a new start counts.
        if (brk_wait_q) begin
          if (rxs) brk_wait_d = 1'b0;
        end else if (!rxs) begin
          state_d  = ST_START;
          tcnt_d   = '0;
          bitcnt_d = '0;
          data_d   = '0;
          cfg_d    = cfg;
          perr_d   = 1'b0;
          ferr_d   = 1'b0;
          allz_d   = 1'b1;
        end
      end
      ST_START: begin
        if (mid && bit_val)  state_d = ST_IDLE;
        else if (bit_end)    state_d = ST_DATA;
      end
      ST_DATA: begin
        if (mid) begin
          data_d[bitcnt_q] = bit_val;
          allz_d           = allz_q & ~bit_val;
        end
        if (bit_end) begin
          if (bitcnt_q == last_bit)
            state_d = cfg_q[CFG_PEN] ? ST_PARITY : ST_STOP1;
          else
            bitcnt_d = bitcnt_q + 3'd1;
        end
      end
      ST_PARITY: begin
        if (mid) begin
          perr_d = (cfg_q[CFG_PEVEN] ? ^data_q : ~^data_q) != bit_val;
          allz_d = allz_q & ~bit_val;
        end
        if (bit_end) state_d = ST_STOP1;
      end
      ST_STOP1: begin
        // Leaving at mid-bit gives the next start edge half a bit of margin.
        if (mid) begin
          ferr_d = ferr_q | ~bit_val;
          allz_d = allz_q & ~bit_val;
          if (!cfg_q[CFG_STOP]) state_d = ST_PUSH;
        end else if (bit_end) begin
          state_d = ST_STOP2;
        end
      end
      ST_STOP2: begin
        if (mid) begin
          ferr_d  = ferr_q | ~bit_val;
          allz_d  = allz_q & ~bit_val;
          state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        push_req   = can_push;
        ovr_set    = !can_push;
        brk_wait_d = allz_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Set takes priority over a simultaneous clear.
    overrun_d = ovr_set | (overrun_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= '1;
      state_q    <= ST_IDLE;
      tcnt_q     <= '0;
      brk_wait_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      brk_wait_q <= brk_wait_d;
      overrun_q  <= overrun_d;
    end
  end

  // Frame data is always reinitialised on the start edge, so it needs no reset.
  always_ff @(posedge clk) begin
    bitcnt_q <= bitcnt_d;
    data_q   <= data_d;
    s7_q     <= s7_d;
    s8_q     <= s8_d;
    cfg_q    <= cfg_d;
    perr_q   <= perr_d;
    ferr_q   <= ferr_d;
    allz_q   <= allz_d;
  end

  // ---- stage: output FIFO
  always_comb begin
    push_entry.brk  = allz_q;
    push_entry.ferr = ferr_q;
    push_entry.perr = perr_q;
    push_entry.data = data_q;
    rd_valid        = !fifo_empty;
    rd_pop          = rd_valid && rd_ready;
    can_push        = !fifo_full || rd_pop;
  end

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_req),
    .wr_data (push_entry),
    .rd_en   (rd_pop),
    .rd_data (fifo_rd),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (level)
  );

  // Head fields are forced to 0 while empty so nothing stale shows.
  always_comb begin
    head    = rx_entry_t'(fifo_rd);
    rd_data = '0;
    rd_perr = 1'b0;
    rd_ferr = 1'b0;
    rd_brk  = 1'b0;
    if (rd_valid) begin
      rd_data = head.data;
      rd_perr = head.perr;
      rd_ferr = head.ferr;
      rd_brk  = head.brk;
    end
    overrun = overrun_q;
    busy    = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DEPTH = 4;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       tick16  = 1'b0;
  logic [4:0] cfg     = 5'b00011;
  logic       rx_sn   = 1'b1;
  logic       rd_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rd_perr, rd_ferr, rd_brk, rd_valid, overrun, busy;
  logic [$clog2(DEPTH):0] level;

  int checks   = 0;
  int errors   = 0;
  int tick_div = 1;
  int tick_cnt = 0;

  logic [10:0] exp_q[$];
  logic        exp_ovr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick16   (tick16),
    .cfg      (cfg),
    .rx_sn    (rx_sn),
    .rd_data  (rd_data),
    .rd_perr  (rd_perr),
    .rd_ferr  (rd_ferr),
    .rd_brk   (rd_brk),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .level    (level),
    .overrun  (overrun),
    .clr_err  (clr_err),
    .busy     (busy)
  );

  // tick16 pulses once every tick_div clocks
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tick_cnt >= tick_div - 1) begin
        tick16   = 1'b1;
        tick_cnt = 0;
      end else begin
        tick16   = 1'b0;
        tick_cnt = tick_cnt + 1;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(posedge clk);
      if (tick16) c++;
    end
  endtask

  task automatic idle(input int n);
    rx_sn = 1'b1;
    wait_ticks(n);
    #1;
  endtask

  task automatic model_push(input logic [10:0] e);
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else exp_ovr = 1'b1;
  endtask

  // mode 0: plain; 1: check rd_valid latency; 2: pop during the push cycle
  task automatic send_frame(input logic [7:0] d, input logic [4:0] c, input bit flip,
                            input bit s1_low, input bit s2_low, input bit scramble, input int mode);
    logic        b[$];
    logic [7:0]  dm;
    logic        par, allz, ferr, perr;
    int          len;
    len = int'(c[1:0]) + 5;
    dm  = '0;
    for (int i = 0; i < len; i++) dm[i] = d[i];
    b.push_back(1'b0);
    for (int i = 0; i < len; i++) b.push_back(dm[i]);
    if (c[3]) begin
      par = (c[2] ? ^dm : ~^dm) ^ flip;
      b.push_back(par);
    end
    b.push_back(~s1_low);
    if (c[4]) b.push_back(~s2_low);
    allz = 1'b1;
    for (int i = 1; i < b.size(); i++) if (b[i]) allz = 1'b0;
    ferr = s1_low | (c[4] & s2_low);
    perr = c[3] & flip;
    cfg  = c;
    for (int i = 0; i < b.size(); i++) begin
      rx_sn = b[i];
      if (i == 0 && scramble) begin
        wait_ticks(8); #1;
        cfg = 5'($urandom);
        wait_ticks(8); #1;
      end else if (i == b.size() - 1 && mode != 0) begin
        wait_ticks(13); #1;
        if (mode == 1) check("t1_valid_before", 32'(rd_valid), 32'd0);
        else rd_ready = 1'b1;
        step();
        if (mode == 1) check("t1_valid_latency", 32'(rd_valid), 32'd1);
        else rd_ready = 1'b0;
        wait_ticks(2); #1;
      end else begin
        wait_ticks(16); #1;
      end
    end
    rx_sn = 1'b1;
    if (mode == 2 && exp_q.size() > 0) exp_q.delete(0);
    model_push({allz, ferr, perr, dm});
  endtask

  task automatic drain(input string tag);
    check({tag, "_level"}, 32'(level), 32'(exp_q.size()));
    check({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
    while (exp_q.size() > 0) begin
      check({tag, "_valid"}, 32'(rd_valid), 32'd1);
      check({tag, "_entry"}, 32'({rd_brk, rd_ferr, rd_perr, rd_data}), 32'(exp_q[0]));
      exp_q.delete(0);
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
    end
    check({tag, "_empty"}, 32'(rd_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] rd;
    logic [4:0] rc;
    bit         fl, s1, s2;
    int         k;

    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_head", 32'({rd_brk, rd_ferr, rd_perr, rd_data}), 32'd0);

    // 8N1 0xA5 with latency check
    send_frame(8'hA5, 5'b00011, 0, 0, 0, 0, 1);
    idle(8);
    check("t1_data", 32'(rd_data), 32'hA5);
    drain("t1");

    // 5E1 0x13, good then flipped parity
    send_frame(8'h13, 5'b01100, 0, 0, 0, 0, 0);
    idle(16);
    check("t2_data", 32'(rd_data), 32'h13);
    check("t2_perr_ok", 32'(rd_perr), 32'd0);
    drain("t2a");
    send_frame(8'h13, 5'b01100, 1, 0, 0, 0, 0);
    idle(16);
    check("t2_data_bad", 32'(rd_data), 32'h13);
    check("t2_perr_bad", 32'(rd_perr), 32'd1);
    drain("t2b");

    // 8N2 second stop low, then break
    send_frame(8'h3C, 5'b10011, 0, 0, 1, 0, 0);
    idle(16);
    check("t3_ferr", 32'(rd_ferr), 32'd1);
    drain("t3a");
    rx_sn = 1'b0;
    wait_ticks(352); #1;
    check("t3_brk_idle_wait", 32'(busy), 32'd0);
    model_push(11'h600);
    idle(32);
    check("t3_brk_level", 32'(level), 32'd1);
    drain("t3b");

    // short glitch
    rx_sn = 1'b0;
    repeat (6) step();
    rx_sn = 1'b1;
    check("t4_busy_glitch", 32'(busy), 32'd1);
    idle(32);
    check("t4_busy_after", 32'(busy), 32'd0);
    check("t4_level", 32'(level), 32'd0);

    // overrun with five frames
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 5'b00011, 0, 0, 0, 0, 0);
      idle(4);
    end
    check("t5_level", 32'(level), 32'd4);
    check("t5_overrun", 32'(overrun), 32'd1);
    check("t5_head", 32'(rd_data), 32'h01);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    exp_ovr = 1'b0;
    check("t5_clr", 32'(overrun), 32'd0);

    // push and pop together while full
    send_frame(8'h06, 5'b00011, 0, 0, 0, 0, 2);
    idle(4);
    check("t6_level", 32'(level), 32'd4);
    check("t6_overrun", 32'(overrun), 32'd0);
    drain("t6");

    // reset mid-DATA
    send_frame(8'h55, 5'b00011, 0, 0, 0, 0, 0);
    idle(4);
    check("rst_mid_pre_level", 32'(level), 32'd1);
    rx_sn = 1'b0;
    wait_ticks(40); #1;
    check("rst_mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    rx_sn = 1'b1;
    step();
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_level", 32'(level), 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    exp_ovr = 1'b0;
    idle(48);
    check("rst_mid_no_push", 32'(level), 32'd0);
    check("rst_mid_idle", 32'(busy), 32'd0);

    // randomized groups against the queue model
    for (int g = 0; g < 6; g++) begin
      tick_div = int'($urandom_range(1, 3));
      k = int'($urandom_range(1, 6));
      for (int j = 0; j < k; j++) begin
        rc = 5'($urandom);
        rd = 8'($urandom);
        fl = bit'($urandom_range(0, 1));
        s1 = ($urandom_range(0, 4) == 0);
        s2 = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 7) == 0) begin
          rd = 8'h00;
          s1 = 1'b1;
          s2 = 1'b1;
          fl = ~rc[2];
        end
        send_frame(rd, rc, fl, s1, s2, 1, 0);
        idle(16);
      end
      drain("rnd");
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      exp_ovr = 1'b0;
      check("rnd_clr", 32'(overrun), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
